// File: rtl/alu_writeback.sv
// ALU result writeback stage: one-entry holding slot in front of a small register
// file, with commit-gated update of the C/Z flags and a retire counter.
module alu_writeback #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_data,
    input  logic             res_cout,
    input  logic [AW-1:0]    res_dest,
    input  logic             res_flags_en,
    input  logic             commit_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic [7:0]       retire_cnt,
    output logic             pending
);

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             cout;
        logic [AW-1:0]    dest;
        logic             flags_en;
    } slot_t;

    state_t                       state_q, state_d;
    slot_t                        slot_q;
    logic [NREGS-1:0][WIDTH-1:0]  rf_q;
    logic                         carry_q, zero_q;
    logic [7:0]                   cnt_q;
    logic                         xfer, commit;

    // Ready is forced high in reset so upstream never stalls; those offers are dropped.
    assign res_ready = !rst_n || (state_q == EMPTY) || commit_en;
    assign xfer      = res_valid && res_ready;
    assign commit    = (state_q == FULL) && commit_en;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (commit && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            slot_q  <= '0;
            rf_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                slot_q.data     <= res_data;
                slot_q.cout     <= res_cout;
                slot_q.dest     <= res_dest;
                slot_q.flags_en <= res_flags_en;
            end
            if (commit) begin
                rf_q[slot_q.dest] <= slot_q.data;
                cnt_q             <= cnt_q + 8'd1;
                if (slot_q.flags_en) begin
                    carry_q <= slot_q.cout;
                    zero_q  <= (slot_q.data == '0);
                end
            end
        end
    end

    // No write-to-read bypass: a commit shows up on the read ports one cycle later.
    assign rd_data_a  = rf_q[rd_addr_a];
    assign rd_data_b  = rf_q[rd_addr_b];
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign retire_cnt = cnt_q;
    assign pending    = (state_q == FULL);

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_alu_writeback;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [7:0] res_data = '0;
    logic       res_cout = 1'b0;
    logic [1:0] res_dest = '0;
    logic       res_flags_en = 1'b0;
    logic       commit_en = 1'b0;
    logic [1:0] rd_addr_a = '0;
    logic [1:0] rd_addr_b = '0;
    logic [7:0] rd_data_a, rd_data_b;
    logic       carry_flag, zero_flag;
    logic [7:0] retire_cnt;
    logic       pending;

    int checks = 0;
    int errors = 0;

    alu_writeback #(.WIDTH(8), .NREGS(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_dest(res_dest),
        .res_flags_en(res_flags_en), .commit_en(commit_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .retire_cnt(retire_cnt), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a held result (or none), the architectural registers, flags and a retire count.
    logic [7:0] m_rf[4];
    logic       m_full = 1'b0;
    logic [7:0] m_sdata;
    logic       m_scout, m_sfen;
    logic [1:0] m_sdest;
    logic       m_c = 1'b0, m_z = 1'b0;
    int         m_cnt = 0;

    initial for (int i = 0; i < 4; i++) m_rf[i] = '0;

    always @(posedge clk) begin
        bit take, retire;
        if (!rst_n) begin
            m_full = 1'b0;
            for (int i = 0; i < 4; i++) m_rf[i] = '0;
            m_c = 1'b0; m_z = 1'b0; m_cnt = 0;
        end else begin
            retire = m_full && commit_en;
            take   = res_valid && (!m_full || commit_en);
            if (retire) begin
                m_rf[m_sdest] = m_sdata;
                m_cnt = (m_cnt + 1) % 256;
                if (m_sfen) begin
                    m_c = m_scout;
                    m_z = (m_sdata == 8'd0);
                end
            end
            if (take) begin
                m_sdata = res_data; m_scout = res_cout;
                m_sdest = res_dest; m_sfen = res_flags_en;
                m_full = 1'b1;
            end else if (retire) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("res_ready", res_ready, (!rst_n || !m_full || commit_en));
        chk("pending",   pending, m_full);
        chk("rd_data_a", rd_data_a, m_rf[rd_addr_a]);
        chk("rd_data_b", rd_data_b, m_rf[rd_addr_b]);
        chk("carry",     carry_flag, m_c);
        chk("zero",      zero_flag, m_z);
        chk("retire",    retire_cnt, m_cnt[7:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] d, input logic c, input logic [1:0] dst, input logic fen);
        res_valid = 1'b1; res_data = d; res_cout = c; res_dest = dst; res_flags_en = fen;
    endtask

    task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp, input string nm);
        rd_addr_a = idx; rd_addr_b = idx;
        #1;
        chk({nm, "_a"}, rd_data_a, exp);
        chk({nm, "_b"}, rd_data_b, exp);
    endtask

    initial begin
        // Reset, with an offer that must be dropped.
        tick();
        offer(8'hEE, 1'b1, 2'd1, 1'b1);
        commit_en = 1'b1;
        #1 chk("lit_ready_in_reset", res_ready, 1);
        tick();
        rst_n = 1'b1; res_valid = 1'b0;
        tick();
        chk("lit_reset_pending", pending, 0);
        chk("lit_reset_cnt", retire_cnt, 0);
        chk("lit_reset_flags", {carry_flag, zero_flag}, 0);
        for (int i = 0; i < 4; i++) read_reg(i[1:0], 8'h00, "lit_reset_rf");

        // EMPTY ignores commit_en.
        commit_en = 1'b1;
        tick();
        chk("lit_empty_commit_cnt", retire_cnt, 0);
        commit_en = 1'b0;

        // Add with carry.
        offer(8'h03, 1'b1, 2'd2, 1'b1);
        tick();
        res_valid = 1'b0; commit_en = 1'b1;
        chk("lit_add_pending", pending, 1);
        read_reg(2'd2, 8'h00, "lit_add_nobypass");
        tick();
        commit_en = 1'b0;
        read_reg(2'd2, 8'h03, "lit_add_reg2");
        chk("lit_add_carry", carry_flag, 1);
        chk("lit_add_zero", zero_flag, 0);
        chk("lit_add_cnt", retire_cnt, 1);
        chk("lit_add_pending0", pending, 0);

        // Zero result.
        offer(8'h00, 1'b0, 2'd1, 1'b1);
        tick();
        res_valid = 1'b0; commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        chk("lit_zero_z", zero_flag, 1);
        chk("lit_zero_c", carry_flag, 0);
        chk("lit_zero_cnt", retire_cnt, 2);

        // Stall three cycles, then commit and reload on the same edge.
        offer(8'h55, 1'b1, 2'd3, 1'b1);
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_ready", res_ready, 0);
            chk("lit_stall_pending", pending, 1);
            chk("lit_stall_flags", {carry_flag, zero_flag}, 2'b01);
            read_reg(2'd3, 8'h00, "lit_stall_reg3");
        end
        offer(8'hA0, 1'b0, 2'd0, 1'b0);
        commit_en = 1'b1;
        #1 chk("lit_reload_ready", res_ready, 1);
        tick();
        res_valid = 1'b0;
        chk("lit_reload_pending", pending, 1);
        read_reg(2'd3, 8'h55, "lit_reload_reg3");
        chk("lit_reload_flags", {carry_flag, zero_flag}, 2'b10);
        tick();
        commit_en = 1'b0;
        read_reg(2'd0, 8'hA0, "lit_reload_reg0");
        chk("lit_reload_cnt", retire_cnt, 4);

        // flags_en=0 with a zero result: register written, flags hold.
        offer(8'h00, 1'b0, 2'd3, 1'b0);
        tick();
        res_valid = 1'b0; commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        read_reg(2'd3, 8'h00, "lit_nofl_reg3");
        chk("lit_nofl_flags", {carry_flag, zero_flag}, 2'b10);
        chk("lit_nofl_cnt", retire_cnt, 5);

        // Back-to-back stream up to the 255 -> 0 wrap (251 more commits).
        commit_en = 1'b1;
        for (int i = 0; i < 251; i++) begin
            offer(8'(i * 37 + 1), 1'(i), 2'(i), 1'(i >> 1));
            rd_addr_a = 2'(i + 1); rd_addr_b = 2'(i + 2);
            tick();
        end
        res_valid = 1'b0;
        tick();
        commit_en = 1'b0;
        chk("lit_wrap_cnt", retire_cnt, 0);
        chk("lit_wrap_pending", pending, 0);

        // Reset while FULL with commit_en high: the held result is discarded.
        offer(8'h77, 1'b1, 2'd1, 1'b1);
        tick();
        res_valid = 1'b0;
        rst_n = 1'b0; commit_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("lit_rstfull_pending", pending, 0);
        chk("lit_rstfull_cnt", retire_cnt, 0);
        chk("lit_rstfull_flags", {carry_flag, zero_flag}, 0);
        read_reg(2'd1, 8'h00, "lit_rstfull_reg1");
        commit_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
